adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin arbiter that shares one 32-bit adder/subtractor among several requesters in the pipelined RISC-V core. Candidates include the multi-cycle multiply/divide sequencer, the CSR/counter-update path and the address-generation helper. Each requester presents operands through a valid/ready handshake. The block grants one request per cycle, computes a + b or a − b, and returns the registered result with the requester ID through a one-entry output slot that supports backpressure.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- WIDTH, 32, operand/result width in bits
- ID_W, $clog2(NUM_REQ), width of the requester ID
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high (one-hot or zero)
- req_a  input  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  input  NUM_REQ*WIDTH  operand B, same packing as req_a
- req_sub  input  NUM_REQ  1 = subtract (a − b), 0 = add
- rsp_valid  output  1  result slot holds a valid result
- rsp_ready  input  1  consumer accepts the result
- rsp_id  output  ID_W  index of the requester that produced the result
- rsp_sum  output  WIDTH  result, modulo 2^WIDTH
- rsp_cout  output  1  carry out of the MSB (for subtract: 1 = no borrow)
- rsp_ovf  output  1  signed two's-complement overflow

## Operation
- Arithmetic:
  - Adder computes a + (sub ? ~b : b) + sub at WIDTH+1 bits.
  - rsp_sum takes the low WIDTH bits; rsp_cout takes bit WIDTH.
  - rsp_ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the inverted-or-not B.
- Slot free condition: slot_free = !rsp_valid || rsp_ready.
- Arbitration is combinational from req_valid and a round-robin pointer ptr:
  - Search starts at index ptr and ascends, wrapping modulo NUM_REQ.
  - The first requester with valid high is the winner.
  - req_ready[winner] = slot_free && reset_n. All other bits are 0.
- Transfer happens when req_valid[i] && req_ready[i]. On the next clock edge:
  - the slot loads sum/cout/ovf and rsp_id = i, and sets rsp_valid = 1;
  - ptr becomes (i+1) mod NUM_REQ.
- ptr holds its value on any cycle with no transfer.
- If rsp_ready is high and there is no new transfer, rsp_valid clears on the next edge.
- While rsp_valid && !rsp_ready:
  - all rsp_* outputs hold stable;
  - req_ready is all 0.
- Requester rules:
  - Once valid is raised, the requester holds valid and operands stable until it sees ready.
  - A requester may drop valid only after a transfer.
- Starvation bound: an asserted request is granted within NUM_REQ transfers.

## Timing
- Latency: transfer cycle N produces rsp_valid = 1 in cycle N+1.
- Throughput: one result per cycle while rsp_ready is held high.
- Simultaneous drain and fill: if rsp_ready is high while rsp_valid is high and a new transfer occurs, the slot reloads in the same edge. rsp_valid stays 1 with no bubble.
- Reset values (asynchronous, applied immediately on reset_n low):
  - rsp_valid = 0, rsp_sum = 0, rsp_id = 0, rsp_cout = 0, rsp_ovf = 0;
  - ptr = 0;
  - req_ready = 0 while reset_n is low.
- Reset mid-operation: a pending result is discarded without being presented. No grant is issued until the first edge after reset_n rises; the combinational grant is valid in that same cycle.
- Wrap-around: ptr = NUM_REQ−1 followed by a grant moves ptr to 0.

## Test plan
- Single add: requester 0, a = 4, b = 3, add → req_ready = 3'b001 in the same cycle. Next cycle: rsp_valid = 1, rsp_sum = 7, rsp_id = 0, cout = 0, ovf = 0.
- Arithmetic edge cases on requester 1:
  - 0xFFFFFFFF + 0x5EFFFFFF → 0x5EFFFFFE, cout = 1, ovf = 0.
  - 0x7FFFFFFF + 1 → 0x80000000, ovf = 1.
  - sub 0 − 10 → 0xFFFFFFF6, cout = 0, ovf = 0.
  - sub 10 − 5 → 5, cout = 1.
- Round-robin fairness: all three requesters valid continuously with rsp_ready = 1 after reset → grants and rsp_id follow 0, 1, 2, 0, 1, 2 in consecutive cycles with rsp_valid steady at 1.
- Backpressure:
  - Hold rsp_ready = 0 for 5 cycles with rsp_valid = 1 → req_ready = 0 and all rsp_* outputs unchanged.
  - Raise rsp_ready → a grant occurs in that cycle and the new result appears in the next cycle.
- Pointer holds on idle: grant requester 2, idle 3 cycles, then requesters 0 and 2 both valid → requester 0 is granted (ptr = 0 after wrap).
- Reset mid-operation: drop reset_n between clock edges while rsp_valid = 1 → rsp_valid = 0 and req_ready = 0 immediately. After release, the first grant goes to the lowest valid index starting from 0.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of one shared WIDTH-bit adder/subtractor.
// The winner's operands are added or subtracted, and the result goes into a one-entry output slot.
module adder_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]         req_sub,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_cout,
  output logic                       rsp_ovf
);

  // Handshake: a beat moves on a clock edge when valid && ready are both high in the cycle before it.
  // A requester holds its valid and operands until it sees ready.
  // The slot drives rsp_* unchanged until rsp_ready takes the result.
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_ovf_q, rsp_ovf_d;

  logic             slot_free;
  logic             any_valid;
  logic             transfer;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  idx_id;
  int               idx;
  logic [WIDTH-1:0] op_a, op_b, op_b_eff;
  logic             op_sub;
  logic [WIDTH:0]   full_sum;
  logic             ovf;

  assign slot_free = !rsp_valid_q || rsp_ready;

  // The search starts at ptr and wraps around. The first valid requester found wins.
  always_comb begin
    any_valid = 1'b0;
    win_id    = '0;
    idx       = 0;
    idx_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx    = (int'(ptr_q) + k) % NUM_REQ;
      idx_id = ID_W'(idx);
      if (!any_valid && req_valid[idx_id]) begin
        any_valid = 1'b1;
        win_id    = idx_id;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (any_valid && slot_free && reset_n) req_ready[win_id] = 1'b1;
  end

  assign transfer = |req_ready;

  assign op_a     = req_a[win_id*WIDTH +: WIDTH];
  assign op_b     = req_b[win_id*WIDTH +: WIDTH];
  assign op_sub   = req_sub[win_id];
  assign op_b_eff = op_sub ? ~op_b : op_b;
  assign full_sum = {1'b0, op_a} + {1'b0, op_b_eff} + {{WIDTH{1'b0}}, op_sub};
  assign ovf      = (op_a[WIDTH-1] == op_b_eff[WIDTH-1]) &&
                    (full_sum[WIDTH-1] != op_a[WIDTH-1]);

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_ovf_d   = rsp_ovf_q;
    if (transfer) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = win_id;
      rsp_sum_d   = full_sum[WIDTH-1:0];
      rsp_cout_d  = full_sum[WIDTH];
      rsp_ovf_d   = ovf;
      ptr_d       = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: an arithmetic vector table followed by hand-written sequences
// for round-robin order, backpressure, pointer hold and mid-operation reset.
module tb_adder_arbiter;
  localparam int NUM_REQ = 3;
  localparam int WIDTH   = 32;
  localparam int ID_W    = $clog2(NUM_REQ);

  logic                     clk, reset_n;
  logic [NUM_REQ-1:0]       req_valid, req_ready, req_sub;
  logic [NUM_REQ*WIDTH-1:0] req_a, req_b;
  logic                     rsp_valid, rsp_ready, rsp_cout, rsp_ovf;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_sum;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [ID_W-1:0]  id_q[$];

  typedef struct {
    int               req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;
  vec_t vecs[8];

  adder_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic sub);
    req_valid[i]               = 1'b1;
    req_a[i*WIDTH +: WIDTH]    = a;
    req_b[i*WIDTH +: WIDTH]    = b;
    req_sub[i]                 = sub;
  endtask

  task automatic check_rsp(input string tag, input int id, input logic [WIDTH-1:0] sum,
                           input logic cout, input logic ovf);
    check({tag, " rsp_valid"}, rsp_valid, 1'b1);
    check({tag, " rsp_id"},    rsp_id,    id);
    check({tag, " rsp_sum"},   rsp_sum,   sum);
    check({tag, " rsp_cout"},  rsp_cout,  cout);
    check({tag, " rsp_ovf"},   rsp_ovf,   ovf);
  endtask

  initial begin
    reset_n   = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_sub   = '0;
    req_a     = '0;
    req_b     = '0;

    vecs[0] = '{0, 32'd4,         32'd3,         1'b0, 32'd7,         1'b0, 1'b0};
    vecs[1] = '{1, 32'hFFFF_FFFF, 32'h5EFF_FFFF, 1'b0, 32'h5EFF_FFFE, 1'b1, 1'b0};
    vecs[2] = '{1, 32'h7FFF_FFFF, 32'd1,         1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{1, 32'd0,         32'd10,        1'b1, 32'hFFFF_FFF6, 1'b0, 1'b0};
    vecs[4] = '{1, 32'd10,        32'd5,         1'b1, 32'd5,         1'b1, 1'b0};
    vecs[5] = '{2, 32'h8000_0000, 32'd1,         1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{2, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0,         1'b1, 1'b1};
    vecs[7] = '{0, 32'd5,         32'd5,         1'b1, 32'd0,         1'b1, 1'b0};

    // Reset state: requests are ignored while reset_n is low.
    repeat (2) @(negedge clk);
    req_valid = '1;
    #1;
    check("reset req_ready", req_ready, 3'b000);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rsp_sum",   rsp_sum,   32'd0);
    check("reset rsp_id",    rsp_id,    2'd0);
    check("reset rsp_cout",  rsp_cout,  1'b0);
    check("reset rsp_ovf",   rsp_ovf,   1'b0);
    req_valid = '0;
    @(negedge clk);
    reset_n   = 1'b1;
    rsp_ready = 1'b1;

    // Arithmetic vector table, one lone requester per entry.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      drive(vecs[v].req, vecs[v].a, vecs[v].b, vecs[v].sub);
      #1;
      check($sformatf("vec%0d req_ready", v), req_ready, onehot(vecs[v].req));
      @(negedge clk);
      req_valid = '0;
      #1;
      check_rsp($sformatf("vec%0d", v), vecs[v].req, vecs[v].sum, vecs[v].cout, vecs[v].ovf);
    end
    @(negedge clk);
    #1;
    check("drain rsp_valid", rsp_valid, 1'b0);

    // Round robin after a fresh reset: grants 0,1,2,0,1,2 back to back.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0)
        for (int i = 0; i < NUM_REQ; i++) drive(i, WIDTH'(i * 100), 32'd1, 1'b0);
      #1;
      check($sformatf("rr%0d req_ready", c), req_ready, onehot(c % NUM_REQ));
      if (c > 0) begin
        check($sformatf("rr%0d rsp_valid", c), rsp_valid, 1'b1);
        check($sformatf("rr%0d rsp_id", c), rsp_id, id_q.pop_front());
        check($sformatf("rr%0d rsp_sum", c), rsp_sum, exp_q.pop_front());
      end
      id_q.push_back(ID_W'(c % NUM_REQ));
      exp_q.push_back(WIDTH'((c % NUM_REQ) * 100 + 1));
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    check("rr last rsp_id",  rsp_id,  id_q.pop_front());
    check("rr last rsp_sum", rsp_sum, exp_q.pop_front());

    // Backpressure: slot held for 5 cycles, then drains and refills in one edge.
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(0, 32'd20, 32'd22, 1'b0);
    #1;
    check("bp idle rsp_valid", rsp_valid, 1'b0);
    check("bp first req_ready", req_ready, 3'b001);
    @(negedge clk);
    req_valid = '0;
    drive(1, 32'd9, 32'd1, 1'b0);
    #1;
    check_rsp("bp load", 0, 32'd42, 1'b0, 1'b0);
    check("bp load req_ready", req_ready, 3'b000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("bp%0d req_ready", c), req_ready, 3'b000);
      check_rsp($sformatf("bp%0d", c), 0, 32'd42, 1'b0, 1'b0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp release req_ready", req_ready, 3'b010);
    @(negedge clk);
    req_valid = '0;
    #1;
    check_rsp("bp refill", 1, 32'd10, 1'b0, 1'b0);

    // Pointer holds across idle cycles and then wraps past requester 2.
    @(negedge clk);
    drive(2, 32'd1, 32'd1, 1'b0);
    #1;
    check("hold grant2 req_ready", req_ready, 3'b100);
    @(negedge clk);
    req_valid = '0;
    #1;
    check_rsp("hold grant2", 2, 32'd2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    drive(0, 32'd5, 32'd6, 1'b0);
    drive(2, 32'd7, 32'd8, 1'b0);
    #1;
    check("hold wrap req_ready", req_ready, 3'b001);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    check_rsp("hold wrap", 0, 32'd11, 1'b0, 1'b0);
    check("hold next req_ready", req_ready, 3'b100);
    @(negedge clk);
    req_valid = '0;
    #1;
    check_rsp("hold next", 2, 32'd15, 1'b0, 1'b0);

    // Reset mid-operation: a pending result is dropped and the pointer returns to 0.
    @(negedge clk);
    drive(1, 32'd3, 32'd4, 1'b0);
    #1;
    check("mid grant req_ready", req_ready, 3'b010);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    drive(1, 32'd200, 32'd1, 1'b0);
    drive(2, 32'd300, 32'd1, 1'b0);
    #1;
    check_rsp("mid pending", 1, 32'd7, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid reset rsp_valid", rsp_valid, 1'b0);
    check("mid reset req_ready", req_ready, 3'b000);
    check("mid reset rsp_sum",   rsp_sum,   32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("post reset req_ready", req_ready, 3'b010);
    @(negedge clk);
    req_valid = '0;
    #1;
    check_rsp("post reset", 1, 32'd201, 1'b0, 1'b0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
